fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Program-counter and fetch-control stage directly upstream of instruction memory.
- Drives the 32-bit current_pc that instruction memory decodes combinationally with its lower 12 bits.
- Selects the next PC each cycle from three sources: sequential +1, taken branch via an internal branch-target lookup table, or hold (stall/halt).
- Owns program start/done sequencing for the 9-bit ISA core.

Parameters:
PC_W, 32, width of the program counter
IMEM_AW, 12, instruction memory address bits (4096-entry soft limit)
LUT_AW, 5, branch-target table index width (32 entries)
START_PC, 0, PC loaded on start/restart

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-low; sampled on rising clk
start  input  1  one-cycle pulse: begin/restart program at START_PC
stall  input  1  hold PC this cycle
halt_req  input  1  decoder reports halt instruction at current_pc
branch_taken  input  1  execute resolves a taken branch this cycle
branch_idx  input  LUT_AW  branch-target table index for the taken branch
lut_wr_en  input  1  write branch-target table entry
lut_wr_idx  input  LUT_AW  table write index
lut_wr_data  input  IMEM_AW  absolute target address to store
current_pc  output  PC_W  address to instruction memory
fetch_valid  output  1  current_pc is a live fetch (RUN state, not stalled)
done  output  1  program finished (halt or address overflow)
overflow  output  1  sticky: halted because sequential PC hit the IMEM limit

Behaviour:
- FSM states: IDLE, RUN, HALTED.
- Reset (reset==0 at a clk edge):
  - State goes to IDLE; current_pc=START_PC; fetch_valid=0; done=0; overflow=0.
  - All branch-target table entries cleared to 0.
  - Reset wins over every other input, including mid-RUN.
- IDLE:
  - PC held at START_PC; fetch_valid=0.
  - start at cycle N puts the unit in RUN at N+1 with current_pc=START_PC and fetch_valid=1.
- RUN next-PC priority (highest first):
  - stall: PC, state and all requests held/ignored; fetch_valid=0 during the stalled cycle. Requesters must hold branch_taken/halt_req until stall drops.
  - halt_req: PC holds; HALTED next cycle; done=1 from next cycle.
  - branch_taken: next current_pc = zero-extended table[branch_idx]. Latency is 1 cycle.
  - otherwise, sequential: current_pc+1. If current_pc[IMEM_AW-1:0] == all-ones, do not increment; go to HALTED with done=1 and overflow=1.
- HALTED:
  - PC holds; fetch_valid=0; done and overflow stay high.
  - start clears done and overflow, loads START_PC and enters RUN next cycle.
  - All other inputs ignored.
- start while in RUN: ignored.
- Branch-target table:
  - Synchronous write; combinational read.
  - If a write and a branch hit the same index in one cycle, the branch uses the old entry; the new value is visible the following cycle.
  - Writes are accepted in every state.
- current_pc upper bits [PC_W-1:IMEM_AW] are always 0.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined, two extra output ports are added:
  - fetch_count (32): increments each cycle fetch_valid=1.
  - stall_count (32): increments each RUN cycle with stall=1.
  - Both counters clear on reset and on start, and saturate at all-ones.
- When undefined, the ports and logic are absent and there are no other behavioural differences.

Decomposition:
- Package fetch_pkg holds:
  - the state enum fetch_state_t {IDLE, RUN, HALTED};
  - localparams for PC_W, IMEM_AW and LUT_AW defaults;
  - typedefs pc_t and imem_addr_t.
- One sub-module: branch_target_lut. It holds the table storage, synchronous write, combinational read and reset clear.
- FSM and next-PC mux stay in fetch_unit.

Test Plan:
- Reset then start at cycle 2 -> cycle 3 current_pc=0, fetch_valid=1; cycle 6 current_pc=3.
- Write table[4]=0x020, run to pc=5, branch_taken with idx=4 -> next cycle current_pc=0x020.
- At pc=7, assert stall for 3 cycles with branch_taken held -> pc stays 7 and fetch_valid=0 throughout; cycle after stall drops, pc=table target.
- halt_req at pc=9 -> pc stays 9, done=1 next cycle and held; start -> pc=0, done=0 next cycle.
- Sequential run reaching pc=0xFFF -> next cycle done=1, overflow=1, pc stays 0xFFF.
- reset low mid-RUN at pc=0x10 -> next cycle IDLE, pc=0, table[4] reads 0; with FETCH_PERF_EN, fetch_count=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and default widths for the fetch stage.
package fetch_pkg;

  localparam int unsigned PC_W_DEF    = 32;
  localparam int unsigned IMEM_AW_DEF = 12;
  localparam int unsigned LUT_AW_DEF  = 5;

  typedef logic [PC_W_DEF-1:0]    pc_t;
  typedef logic [IMEM_AW_DEF-1:0] imem_addr_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/branch_target_lut.sv
// Branch-target table: synchronous write, combinational read, cleared on reset.
module branch_target_lut #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 12
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_idx,
  input  logic [DW-1:0] i_wr_data,
  input  logic [AW-1:0] i_rd_idx,
  output logic [DW-1:0] o_rd_data
);

  logic [DW-1:0] r_mem [2**AW];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 2**AW; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_wr_en) begin
      r_mem[i_wr_idx] <= i_wr_data;
    end
  end

  // A same-cycle write to the read index is seen only from the next cycle.
  assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/fetch_unit.sv
// PC generation and program start/done sequencing ahead of instruction memory.
// Optional perf counters (fetch_count, stall_count) enabled by FETCH_PERF_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned PC_W     = PC_W_DEF,
  parameter int unsigned IMEM_AW  = IMEM_AW_DEF,
  parameter int unsigned LUT_AW   = LUT_AW_DEF,
  parameter int unsigned START_PC = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stall,
  input  logic               halt_req,
  input  logic               branch_taken,
  input  logic [LUT_AW-1:0]  branch_idx,
  input  logic               lut_wr_en,
  input  logic [LUT_AW-1:0]  lut_wr_idx,
  input  logic [IMEM_AW-1:0] lut_wr_data,
  output logic [PC_W-1:0]    current_pc,
  output logic               fetch_valid,
  output logic               done,
  output logic               overflow
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        fetch_count,
  output logic [31:0]        stall_count
`endif
);

  localparam logic [IMEM_AW-1:0] StartAddr = IMEM_AW'(START_PC);

  fetch_state_t       r_state;
  logic [IMEM_AW-1:0] r_pc;
  logic               r_done;
  logic               r_overflow;
  logic [IMEM_AW-1:0] w_lut_rd;

  branch_target_lut #(
    .AW (LUT_AW),
    .DW (IMEM_AW)
  ) u_lut (
    .i_clk     (clk),
    .i_rst_n   (reset),
    .i_wr_en   (lut_wr_en),
    .i_wr_idx  (lut_wr_idx),
    .i_wr_data (lut_wr_data),
    .i_rd_idx  (branch_idx),
    .o_rd_data (w_lut_rd)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_pc       <= StartAddr;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= RUN;
            r_pc    <= StartAddr;
          end
        end
        RUN: begin
          if (!stall) begin
            if (halt_req) begin
              r_state <= HALTED;
              r_done  <= 1'b1;
            end else if (branch_taken) begin
              r_pc <= w_lut_rd;
            end else if (&r_pc) begin
              // Sequential fetch would leave instruction memory: stop here.
              r_state    <= HALTED;
              r_done     <= 1'b1;
              r_overflow <= 1'b1;
            end else begin
              r_pc <= r_pc + IMEM_AW'(1);
            end
          end
        end
        HALTED: begin
          if (start) begin
            r_state    <= RUN;
            r_pc       <= StartAddr;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign current_pc  = PC_W'(r_pc);
  assign fetch_valid = (r_state == RUN) && !stall;
  assign done        = r_done;
  assign overflow    = r_overflow;

`ifdef FETCH_PERF_EN
  logic        w_start_ok;
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  // start in RUN is ignored, so it does not clear the counters either.
  assign w_start_ok = start && (r_state != RUN);

  always_ff @(posedge clk) begin
    if (!reset || w_start_ok) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (fetch_valid && !(&r_fetch_cnt)) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      if ((r_state == RUN) && stall && !(&r_stall_cnt)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign fetch_count = r_fetch_cnt;
  assign stall_count = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic        stall;
  logic        halt_req;
  logic        branch_taken;
  logic [4:0]  branch_idx;
  logic        lut_wr_en;
  logic [4:0]  lut_wr_idx;
  logic [11:0] lut_wr_data;
  logic [31:0] current_pc;
  logic        fetch_valid;
  logic        done;
  logic        overflow;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stall        (stall),
    .halt_req     (halt_req),
    .branch_taken (branch_taken),
    .branch_idx   (branch_idx),
    .lut_wr_en    (lut_wr_en),
    .lut_wr_idx   (lut_wr_idx),
    .lut_wr_data  (lut_wr_data),
    .current_pc   (current_pc),
    .fetch_valid  (fetch_valid),
    .done         (done),
    .overflow     (overflow)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count  (fetch_count),
    .stall_count  (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic lut_write(input logic [4:0] idx, input logic [11:0] data);
    lut_wr_en   = 1'b1;
    lut_wr_idx  = idx;
    lut_wr_data = data;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; stall = 1'b0; halt_req = 1'b0;
    branch_taken = 1'b0; branch_idx = '0;
    lut_wr_en = 1'b0; lut_wr_idx = '0; lut_wr_data = '0;

    step(); step();
    check("rst_pc", current_pc, 32'h0);
    check("rst_valid", 32'(fetch_valid), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);

    reset = 1'b1;
    step();
    check("idle_valid", 32'(fetch_valid), 32'h0);

    start = 1'b1;
    step();
    start = 1'b0;
    check("start_pc", current_pc, 32'h0);
    check("start_valid", 32'(fetch_valid), 32'h1);
    step(); step(); step();
    check("seq_pc3", current_pc, 32'h3);

    lut_write(5'd4, 12'h020);
    step();
    lut_wr_en = 1'b0;
    step();
    check("seq_pc5", current_pc, 32'h5);
    branch_taken = 1'b1; branch_idx = 5'd4;
    step();
    check("branch_pc", current_pc, 32'h020);

    // Write and branch on the same index: old entry wins.
    lut_write(5'd4, 12'h0AA);
    step();
    lut_wr_en = 1'b0;
    check("wr_collide_old", current_pc, 32'h020);
    step();
    branch_taken = 1'b0;
    check("wr_collide_new", current_pc, 32'h0AA);

    lut_write(5'd2, 12'h007);
    step();
    lut_wr_en = 1'b0;
    check("seq_after_br", current_pc, 32'h0AB);
    branch_taken = 1'b1; branch_idx = 5'd2;
    step();
    check("br_to_7", current_pc, 32'h7);

    stall = 1'b1; branch_idx = 5'd4;
    #1;
    check("stall_valid_now", 32'(fetch_valid), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", current_pc, 32'h7);
      check("stall_valid", 32'(fetch_valid), 32'h0);
    end
    stall = 1'b0;
    #1;
    check("unstall_valid", 32'(fetch_valid), 32'h1);
    step();
    check("unstall_branch", current_pc, 32'h0AA);
`ifdef FETCH_PERF_EN
    check("stall_count", stall_count, 32'd3);
`endif

    branch_idx = 5'd2;
    step();
    branch_taken = 1'b0;
    step(); step();
    check("pre_halt_pc", current_pc, 32'h9);
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    check("halt_pc", current_pc, 32'h9);
    check("halt_done", 32'(done), 32'h1);
    check("halt_valid", 32'(fetch_valid), 32'h0);
    check("halt_ovf", 32'(overflow), 32'h0);
    branch_taken = 1'b1; branch_idx = 5'd4;
    step();
    branch_taken = 1'b0;
    check("halted_ignores_pc", current_pc, 32'h9);
    check("halted_done_hold", 32'(done), 32'h1);

    start = 1'b1;
    step();
    check("restart_pc", current_pc, 32'h0);
    check("restart_done", 32'(done), 32'h0);
    check("restart_valid", 32'(fetch_valid), 32'h1);
    step();
    start = 1'b0;
    check("start_in_run_ign", current_pc, 32'h1);

    lut_write(5'd1, 12'hFFD);
    step();
    lut_wr_en = 1'b0;
    branch_taken = 1'b1; branch_idx = 5'd1;
    step();
    branch_taken = 1'b0;
    check("br_to_ffd", current_pc, 32'hFFD);
    step(); step();
    check("pc_fff", current_pc, 32'h0000_0FFF);
    check("pc_fff_done", 32'(done), 32'h0);
    step();
    check("ovf_pc", current_pc, 32'h0000_0FFF);
    check("ovf_done", 32'(done), 32'h1);
    check("ovf_flag", 32'(overflow), 32'h1);
    check("ovf_valid", 32'(fetch_valid), 32'h0);
    step();
    check("ovf_sticky", 32'(overflow), 32'h1);

    start = 1'b1;
    step();
    start = 1'b0;
    check("ovf_restart_pc", current_pc, 32'h0);
    check("ovf_restart_flag", 32'(overflow), 32'h0);
    lut_write(5'd3, 12'h010);
    step();
    lut_wr_en = 1'b0;
    branch_taken = 1'b1; branch_idx = 5'd3;
    step();
    branch_taken = 1'b0;
    check("pc_10", current_pc, 32'h10);

    reset = 1'b0;
    step();
    reset = 1'b1;
    check("midrun_rst_pc", current_pc, 32'h0);
    check("midrun_rst_valid", 32'(fetch_valid), 32'h0);
    check("midrun_rst_done", 32'(done), 32'h0);
`ifdef FETCH_PERF_EN
    check("midrun_rst_fcnt", fetch_count, 32'h0);
`endif
    step();
    check("post_rst_idle_pc", current_pc, 32'h0);

    // Table cleared by reset: branch via entry 4 must land on 0.
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("post_rst_pc1", current_pc, 32'h1);
    branch_taken = 1'b1; branch_idx = 5'd4;
    step();
    branch_taken = 1'b0;
    check("lut_cleared", current_pc, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
